instr_fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register for one core of the multicore MIPS32 processor.

---
 rtl/cpu_defs_pkg.sv | 43 ++++
 rtl/instr_fetch_stage_if.sv | 27 ++
 rtl/fetch_perf_counters.sv | 27 ++
 rtl/instr_fetch_stage.sv | 105 ++++++++++
 tb/tb_instr_fetch_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS32 core: fetch FSM encodings, IF/ID record,
// NOP encoding and the opcode/funct values decoded by the ID-stage control unit.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] funct;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [31:0] instr);
        decode_fields = '{opcode: instr[31:26], rs: instr[25:21],
                          rt: instr[20:16], funct: instr[5:0]};
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory bus plus ID-stage stall/redirect and the IF/ID register outputs.
// master = fetch stage, slave = memory / ID stage side.
interface instr_fetch_stage_if
    import cpu_defs_pkg::*;
#(
    parameter int IM_ADDR_W = 10
);
    logic [IM_ADDR_W-1:0] IM_Addr;
    logic [31:0]          IM_Data;
    logic                 ID_stall;
    logic                 redirect;
    logic [31:0]          redirect_target;
    logic [31:0]          IF_ID_Instruction;
    logic [31:0]          IF_ID_PCPlus4;
    logic                 IF_ID_Valid;
    instr_fields_t        IF_ID_Fields;

    modport master (
        output IM_Addr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Fields,
        input  IM_Data, ID_stall, redirect, redirect_target
    );

    modport slave (
        input  IM_Addr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Fields,
        output IM_Data, ID_stall, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_perf_counters.sv
// Per-core scoring counters: cycles spent running and instructions accepted into IF/ID.
module fetch_perf_counters (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cycle_en_i,
    input  logic        fetch_en_i,
    output logic [31:0] cycle_count_o,
    output logic [31:0] fetch_count_o
);
    logic [31:0] cycle_q;
    logic [31:0] fetch_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and sits inside the clocked block.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cycle_q <= 32'h0;
            fetch_q <= 32'h0;
        end else begin
            if (cycle_en_i) cycle_q <= cycle_q + 32'd1;
            if (fetch_en_i) fetch_q <= fetch_q + 32'd1;
        end
    end

    assign cycle_count_o = cycle_q;
    assign fetch_count_o = fetch_q;
endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage with PC, next-PC mux, IF/ID pipeline register and start/halt FSM
// for one core of the multicore MIPS32 processor.
module instr_fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IM_ADDR_W  = 10,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    instr_fetch_stage_if.master bus,
    output logic [31:0]         PC,
    output logic                running,
    output logic                halted,
    output logic [31:0]         cycle_count,
    output logic [31:0]         fetch_count
);
    fetch_state_e state_q;
    logic         running_q;
    logic         halted_q;
    logic [31:0]  pc_q, pc_d;
    if_id_t       if_id_q, if_id_d;

    logic        in_run;
    logic        is_halt_word;
    logic        accept;
    logic [31:0] pc_plus4;

    assign in_run       = (state_q == FETCH_RUN);
    assign is_halt_word = (bus.IM_Data == HALT_INSTR);
    assign pc_plus4     = pc_q + 32'd4;
    assign accept       = in_run && !bus.ID_stall && !bus.redirect && !is_halt_word;

    // Stall outranks redirect: branch operands are not ready while ID stalls.
    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = IF_ID_BUBBLE;
        if (in_run) begin
            if (bus.ID_stall) begin
                if_id_d = if_id_q;
            end else if (bus.redirect) begin
                pc_d = bus.redirect_target & ~32'h3;
            end else if (!is_halt_word) begin
                pc_d    = pc_plus4;
                if_id_d = '{instr: bus.IM_Data, pc_plus4: pc_plus4, valid: 1'b1};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= FETCH_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            pc_q      <= RESET_PC;
            if_id_q   <= IF_ID_BUBBLE;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            case (state_q)
                FETCH_IDLE: begin
                    if (start) begin
                        state_q   <= FETCH_RUN;
                        running_q <= 1'b1;
                    end
                end
                FETCH_RUN: begin
                    if (!bus.ID_stall && !bus.redirect && is_halt_word) begin
                        state_q   <= FETCH_HALT;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                FETCH_HALT: ;
                default: begin
                    state_q   <= FETCH_IDLE;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    fetch_perf_counters u_perf (
        .Clk           (Clk),
        .Rst           (Rst),
        .cycle_en_i    (in_run),
        .fetch_en_i    (accept),
        .cycle_count_o (cycle_count),
        .fetch_count_o (fetch_count)
    );

    assign bus.IM_Addr           = pc_q[IM_ADDR_W+1:2];
    assign bus.IF_ID_Instruction = if_id_q.instr;
    assign bus.IF_ID_PCPlus4     = if_id_q.pc_plus4;
    assign bus.IF_ID_Valid       = if_id_q.valid;
    assign bus.IF_ID_Fields      = decode_fields(if_id_q.instr);

    assign PC      = pc_q;
    assign running = running_q;
    assign halted  = halted_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed table-driven bench for instr_fetch_stage with a small instruction-memory model.
module tb_instr_fetch_stage;
    import cpu_defs_pkg::*;

    localparam int          AW   = 10;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] PC;
    logic        running, halted;
    logic [31:0] cycle_count, fetch_count;
    logic [31:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_stage_if #(.IM_ADDR_W(AW)) bus ();

    instr_fetch_stage #(
        .RESET_PC   (32'h0),
        .IM_ADDR_W  (AW),
        .HALT_INSTR (HALT)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .bus         (bus),
        .PC          (PC),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count),
        .fetch_count (fetch_count)
    );

    always #5 Clk = ~Clk;

    assign bus.IM_Data = mem[bus.IM_Addr];

    typedef struct {
        logic        rst, start, stall, redir;
        logic [31:0] target;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr, pc4;
        logic        run, halt;
        logic [31:0] fcnt, ccnt;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [31:0] addi_word(input int i);
        return 32'h2001_0000 + 32'(i);
    endfunction

    function automatic vec_t v(input logic rst, start, stall, redir, input logic [31:0] target,
                               input logic [31:0] pc, input logic valid,
                               input logic [31:0] instr, pc4, input logic run, halt,
                               input logic [31:0] fcnt, ccnt);
        vec_t r;
        r.rst = rst; r.start = start; r.stall = stall; r.redir = redir; r.target = target;
        r.pc = pc; r.valid = valid; r.instr = instr; r.pc4 = pc4;
        r.run = run; r.halt = halt; r.fcnt = fcnt; r.ccnt = ccnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, st, stall, redir, input logic [31:0] target);
        Rst = rst; start = st; bus.ID_stall = stall; bus.redirect = redir; bus.redirect_target = target;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = addi_word(i);
        mem[2] = HALT;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        //         rst  st   stl  red  target         pc            vld  instr          pc4           run  hlt  fcnt ccnt
        vecs.push_back(v(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h4,        1, addi_word(0),   32'h4,        1, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h8,        1, addi_word(1),   32'h8,        1, 0, 2, 2));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h8,        0, 32'h0,          32'h0,        0, 1, 2, 3));
        vecs.push_back(v(0, 1, 0, 0, 32'h0,        32'h8,        0, 32'h0,          32'h0,        0, 1, 2, 3));
        vecs.push_back(v(1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 32'h10,       32'h10,       0, 32'h0,          32'h0,        1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h14,       1, addi_word(4),   32'h14,       1, 0, 1, 2));
        vecs.push_back(v(0, 0, 1, 0, 32'h0,        32'h14,       1, addi_word(4),   32'h14,       1, 0, 1, 3));
        vecs.push_back(v(0, 0, 1, 0, 32'h0,        32'h14,       1, addi_word(4),   32'h14,       1, 0, 1, 4));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h18,       1, addi_word(5),   32'h18,       1, 0, 2, 5));
        vecs.push_back(v(0, 0, 1, 1, 32'h40,       32'h18,       1, addi_word(5),   32'h18,       1, 0, 2, 6));
        vecs.push_back(v(0, 0, 0, 1, 32'h40,       32'h40,       0, 32'h0,          32'h0,        1, 0, 2, 7));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h44,       1, addi_word(16),  32'h44,       1, 0, 3, 8));
        vecs.push_back(v(0, 1, 0, 1, 32'h43,       32'h40,       0, 32'h0,          32'h0,        1, 0, 3, 9));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h44,       1, addi_word(16),  32'h44,       1, 0, 4, 10));
        vecs.push_back(v(0, 0, 0, 1, 32'h24,       32'h24,       0, 32'h0,          32'h0,        1, 0, 4, 11));
        vecs.push_back(v(1, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,          32'h0,        1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h4,        1, addi_word(0),   32'h4,        1, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,        1, 0, 1, 2));
        vecs.push_back(v(0, 0, 0, 0, 32'h0,        32'h0,        1, addi_word(1023), 32'h0,       1, 0, 2, 3));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].redir, vecs[i].target);
            tick();
            check({tag, ".pc"},      PC,                     vecs[i].pc);
            check({tag, ".im_addr"}, 32'(bus.IM_Addr),       32'(vecs[i].pc[AW+1:2]));
            check({tag, ".valid"},   32'(bus.IF_ID_Valid),   32'(vecs[i].valid));
            check({tag, ".instr"},   bus.IF_ID_Instruction,  vecs[i].instr);
            check({tag, ".pc4"},     bus.IF_ID_PCPlus4,      vecs[i].pc4);
            check({tag, ".running"}, 32'(running),           32'(vecs[i].run));
            check({tag, ".halted"},  32'(halted),            32'(vecs[i].halt));
            check({tag, ".fetch"},   fetch_count,            vecs[i].fcnt);
            check({tag, ".cycle"},   cycle_count,            vecs[i].ccnt);
        end
        check("opcode_field", 32'(bus.IF_ID_Fields.opcode), 32'(OP_ADDI));

        // Halt word under stall or redirect must not halt; later plain fetch of it does.
        drive(1, 0, 0, 0, 32'h0); tick();
        drive(0, 1, 0, 0, 32'h0); tick();
        drive(0, 0, 0, 1, 32'h8); tick();
        check("seq.redir_to_halt_pc", PC, 32'h8);
        drive(0, 0, 1, 0, 32'h0); tick();
        check("seq.stall_over_halt", 32'(halted), 32'd0);
        check("seq.stall_pc_hold",   PC,          32'h8);
        drive(0, 0, 0, 1, 32'h0); tick();
        check("seq.redir_over_halt", 32'(halted), 32'd0);
        check("seq.redir_pc",        PC,          32'h0);
        drive(0, 0, 0, 0, 32'h0);
        for (int n = 0; n < 20 && !halted; n++) tick();
        check("seq.halt_reached", 32'(halted),  32'd1);
        check("seq.halt_fetch",   fetch_count,  32'd2);
        check("seq.halt_cycle",   cycle_count,  32'd6);
        check("seq.halt_pc",      PC,           32'h8);
        tick(); tick();
        check("seq.halt_frozen_cycle", cycle_count, 32'd6);
        check("seq.halt_frozen_valid", 32'(bus.IF_ID_Valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
